// File: rtl/gsim_sweep_sched_if.sv
// Handshake and datapath bundle between the sweep scheduler, b-loader, PE and output sink.
// Modport master is the scheduler side; slave is the surrounding datapath/environment.
interface gsim_sweep_sched_if #(
    parameter int N  = 16,
    parameter int XW = 32
);
    localparam int IW = $clog2(N);

    logic          start;
    logic [XW-1:0] tol;
    logic          row_valid;
    logic [IW-1:0] row_idx;
    logic          sweep_last;
    logic          res_valid;
    logic [XW-1:0] res_new;
    logic [XW-1:0] res_old;
    logic          out_valid;
    logic [IW-1:0] out_idx;
    logic          out_ready;
    logic          busy;
    logic [6:0]    iter_cnt;
    logic          converged;
    logic          done;

    modport master (
        input  start, tol, res_valid, res_new, res_old, out_ready,
        output row_valid, row_idx, sweep_last, out_valid, out_idx,
               busy, iter_cnt, converged, done
    );

    modport slave (
        output start, tol, res_valid, res_new, res_old, out_ready,
        input  row_valid, row_idx, sweep_last, out_valid, out_idx,
               busy, iter_cnt, converged, done
    );
endinterface

// File: rtl/gsim_sweep_sched.sv
// Gauss-Seidel iteration scheduler: issues row sweeps to the PE, tracks the largest
// per-sweep update, exits on tolerance or MAX_ITER, then runs the output handshake.
module gsim_sweep_sched #(
    parameter int N        = 16,
    parameter int MAX_ITER = 100,
    parameter int XW       = 32,
    parameter int MIN_ITER = 2
) (
    input logic            clk,
    input logic            reset,
    gsim_sweep_sched_if.master bus
);
    localparam int IW = $clog2(N);
    localparam int CW = IW + 1;
    localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DECIDE, OUT} state_t;

    state_t        state;
    logic [XW-1:0] tol_r;
    logic [XW:0]   max_delta;
    logic [CW-1:0] res_cnt;

    logic signed [XW:0] diff;
    logic [XW:0]        d;
    logic [XW:0]        max_next;
    logic [CW-1:0]      res_cnt_next;
    logic               acct;
    logic [6:0]         k;

    // Sign-extended difference keeps |new - old| exact for any pair of XW-bit inputs.
    always_comb begin
        diff         = {bus.res_new[XW-1], bus.res_new} - {bus.res_old[XW-1], bus.res_old};
        d            = diff[XW] ? $unsigned(-diff) : $unsigned(diff);
        acct         = bus.res_valid && (state == ISSUE || state == DRAIN);
        res_cnt_next = res_cnt + CW'(acct);
        max_next     = (acct && d > max_delta) ? d : max_delta;
        k            = bus.iter_cnt + 7'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            tol_r          <= '0;
            max_delta      <= '0;
            res_cnt        <= '0;
            bus.row_valid  <= 1'b0;
            bus.row_idx    <= '0;
            bus.sweep_last <= 1'b0;
            bus.out_valid  <= 1'b0;
            bus.out_idx    <= '0;
            bus.busy       <= 1'b0;
            bus.iter_cnt   <= '0;
            bus.converged  <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (acct) begin
                res_cnt   <= res_cnt_next;
                max_delta <= max_next;
            end
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse belongs to the finished solve.
                    if (bus.start && !bus.done) begin
                        tol_r          <= bus.tol;
                        bus.iter_cnt   <= '0;
                        bus.converged  <= 1'b0;
                        max_delta      <= '0;
                        res_cnt        <= '0;
                        bus.row_valid  <= 1'b1;
                        bus.row_idx    <= '0;
                        bus.sweep_last <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.row_idx == LAST_ROW) begin
                        bus.row_valid  <= 1'b0;
                        bus.sweep_last <= 1'b0;
                        state          <= DRAIN;
                    end else begin
                        bus.row_idx    <= bus.row_idx + 1'b1;
                        bus.sweep_last <= (bus.row_idx == IW'(N - 2));
                    end
                end
                DRAIN: begin
                    if (res_cnt_next >= CW'(N))
                        state <= DECIDE;
                end
                DECIDE: begin
                    bus.iter_cnt <= k;
                    if (max_delta <= {1'b0, tol_r} && k >= 7'(MIN_ITER)) begin
                        bus.converged <= 1'b1;
                        bus.out_valid <= 1'b1;
                        bus.out_idx   <= '0;
                        state         <= OUT;
                    end else if (k == 7'(MAX_ITER)) begin
                        bus.converged <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.out_idx   <= '0;
                        state         <= OUT;
                    end else begin
                        max_delta     <= '0;
                        res_cnt       <= '0;
                        bus.row_valid <= 1'b1;
                        bus.row_idx   <= '0;
                        state         <= ISSUE;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (bus.out_idx == LAST_ROW) begin
                            bus.out_valid <= 1'b0;
                            bus.out_idx   <= '0;
                            bus.done      <= 1'b1;
                            bus.busy      <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            bus.out_idx <= bus.out_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gsim_sweep_sched.sv
// Directed bench for gsim_sweep_sched with a fixed-latency (3) PE model and a ready-pattern sink.
module tb_gsim_sweep_sched;
    localparam int N = 16, XW = 32, MAX_ITER = 100, MIN_ITER = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gsim_sweep_sched_if #(.N(N), .XW(XW)) bus();
    gsim_sweep_sched #(.N(N), .MAX_ITER(MAX_ITER), .XW(XW), .MIN_ITER(MIN_ITER)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int errors = 0, checks = 0;
    int mode = 0, ready_mode = 0, stray = 0;
    int rows_total, sweeps_seen, order_err, out_xfers, out_cycles, done_cnt;
    int cyc = 0, last_res_cyc = 0, last_gap, exp_row, exp_out, pat_cnt;
    logic prev_rv = 1'b0;
    logic          pv[3];
    logic [XW-1:0] pn[3];
    logic [XW-1:0] po[3];

    // Update magnitude the PE model returns for a given sweep (1-based) and row.
    function automatic logic [XW-1:0] delta_of(input int sw, input int row);
        case (mode)
            1:       return 32'h0001_0000;
            2:       return (sw <= 4) ? 32'h20 : 32'h08;
            3:       return (sw == 5 && row == 7) ? 32'h11 : ((sw <= 4) ? 32'h20 : 32'h08);
            default: return 32'h0;
        endcase
    endfunction

    // PE model, sink and monitor; everything here is evaluated mid-cycle on the falling edge.
    always @(negedge clk) begin
        logic [XW-1:0] o, dv;
        cyc++;
        if (reset) begin
            for (int i = 0; i < 3; i++) pv[i] = 1'b0;
            bus.res_valid = 1'b0;
        end else begin
            bus.res_valid = pv[2];
            bus.res_new   = pn[2];
            bus.res_old   = po[2];
            if (stray != 0) begin
                bus.res_valid = 1'b1;
                bus.res_new   = 32'h7000_0000;
                bus.res_old   = 32'h9000_0000;
            end
            pv[2] = pv[1]; pn[2] = pn[1]; po[2] = po[1];
            pv[1] = pv[0]; pn[1] = pn[0]; po[1] = po[0];
            pv[0] = bus.row_valid;
            o  = (32'(bus.row_idx) * 32'h1357) ^ 32'hFFFF_0000;
            dv = delta_of(sweeps_seen + 1, int'(bus.row_idx));
            if (mode == 4) begin
                po[0] = (bus.row_idx == 0) ? 32'h8000_0000 : o;
                pn[0] = (bus.row_idx == 0) ? 32'h7FFF_FFFF : o;
            end else begin
                po[0] = o;
                pn[0] = bus.row_idx[0] ? o - dv : o + dv;
            end
            if (bus.res_valid) last_res_cyc = cyc;
        end
        bus.out_ready = (ready_mode == 0) ? 1'b1 : (pat_cnt % 3 == 0);
        if (bus.out_valid) begin
            pat_cnt++;
            out_cycles++;
        end
        if (bus.row_valid) begin
            if (!prev_rv && sweeps_seen > 0) last_gap = cyc - last_res_cyc;
            rows_total++;
            if (int'(bus.row_idx) != exp_row || bus.sweep_last !== (bus.row_idx == 4'(N - 1)))
                order_err++;
            exp_row = (exp_row + 1) % N;
            if (bus.row_idx == 4'(N - 1)) sweeps_seen++;
        end else if (bus.sweep_last) begin
            order_err++;
        end
        prev_rv = bus.row_valid;
        if (bus.out_valid && bus.out_ready) begin
            if (int'(bus.out_idx) != exp_out) order_err++;
            exp_out++;
            out_xfers++;
        end
        if (bus.done) done_cnt++;
    end

    task automatic clr_mon();
        rows_total = 0; sweeps_seen = 0; order_err = 0; out_xfers = 0; out_cycles = 0;
        done_cnt = 0; exp_row = 0; exp_out = 0; pat_cnt = 0; last_gap = -1;
    endtask

    task automatic pulse_start(input logic [XW-1:0] t);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.tol   = t;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit tout);
        tout = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            if (done_cnt > 0) begin
                tout = 1'b0;
                break;
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_solve(input logic [XW-1:0] t, input int m, input int rm, output bit tout);
        mode = m;
        ready_mode = rm;
        clr_mon();
        pulse_start(t);
        wait_done(tout);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.row_valid, bus.row_idx, bus.sweep_last, bus.out_valid, bus.out_idx, bus.busy,
             bus.iter_cnt, bus.converged, bus.done} !== '0) begin
            errors++; $display("FAIL reset_outputs: outputs not all zero during reset");
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_converge_exact();
        bit to;
        run_solve(32'h0, 0, 0, to);
        checks++; if (to) begin errors++; $display("FAIL exact_timeout: no done"); end
        checks++; if (sweeps_seen != 2) begin errors++; $display("FAIL exact_sweeps: got %0d want 2", sweeps_seen); end
        checks++; if (rows_total != 32) begin errors++; $display("FAIL exact_rows: got %0d want 32", rows_total); end
        checks++; if (bus.iter_cnt !== 7'd2) begin errors++; $display("FAIL exact_iter: got %0d want 2", bus.iter_cnt); end
        checks++; if (bus.converged !== 1'b1) begin errors++; $display("FAIL exact_conv: got %b want 1", bus.converged); end
        checks++; if (out_xfers != 16) begin errors++; $display("FAIL exact_out: got %0d want 16", out_xfers); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL exact_order: got %0d errs want 0", order_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL exact_done: got %0d want 1", done_cnt); end
        checks++; if (last_gap != 2) begin errors++; $display("FAIL exact_gap: got %0d want 2", last_gap); end
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL exact_idle: busy=%b out_valid=%b want 0 0", bus.busy, bus.out_valid); end
    endtask

    task automatic test_max_iter();
        bit to;
        run_solve(32'h0000_FFFF, 1, 0, to);
        checks++; if (to) begin errors++; $display("FAIL max_timeout: no done"); end
        checks++; if (bus.iter_cnt !== 7'd100) begin errors++; $display("FAIL max_iter: got %0d want 100", bus.iter_cnt); end
        checks++; if (bus.converged !== 1'b0) begin errors++; $display("FAIL max_conv: got %b want 0", bus.converged); end
        checks++; if (sweeps_seen != 100) begin errors++; $display("FAIL max_sweeps: got %0d want 100", sweeps_seen); end
        checks++; if (out_xfers != 16) begin errors++; $display("FAIL max_out: got %0d want 16", out_xfers); end
    endtask

    task automatic test_tolerance();
        bit to;
        run_solve(32'h10, 2, 0, to);
        checks++; if (to || bus.iter_cnt !== 7'd5 || bus.converged !== 1'b1) begin
            errors++; $display("FAIL tol_sweep5: iter=%0d conv=%b want 5 1", bus.iter_cnt, bus.converged); end
        run_solve(32'h10, 3, 0, to);
        checks++; if (to || bus.iter_cnt !== 7'd6 || bus.converged !== 1'b1) begin
            errors++; $display("FAIL tol_sweep6: iter=%0d conv=%b want 6 1", bus.iter_cnt, bus.converged); end
        run_solve(32'h08, 2, 0, to);
        checks++; if (to || bus.iter_cnt !== 7'd5 || bus.converged !== 1'b1) begin
            errors++; $display("FAIL tol_equal: iter=%0d conv=%b want 5 1", bus.iter_cnt, bus.converged); end
        run_solve(32'hFFFF_FFFF, 1, 0, to);
        checks++; if (to || bus.iter_cnt !== 7'd2 || bus.converged !== 1'b1) begin
            errors++; $display("FAIL tol_ones: iter=%0d conv=%b want 2 1", bus.iter_cnt, bus.converged); end
    endtask

    task automatic test_overflow();
        bit to;
        run_solve(32'hFFFF_FFFF, 4, 0, to);
        checks++; if (to || bus.iter_cnt !== 7'd2 || bus.converged !== 1'b1) begin
            errors++; $display("FAIL ovf_fits: iter=%0d conv=%b want 2 1", bus.iter_cnt, bus.converged); end
        run_solve(32'hFFFF_FFFE, 4, 0, to);
        checks++; if (to || bus.iter_cnt !== 7'd100 || bus.converged !== 1'b0) begin
            errors++; $display("FAIL ovf_exceeds: iter=%0d conv=%b want 100 0", bus.iter_cnt, bus.converged); end
    endtask

    task automatic test_backpressure();
        bit to;
        run_solve(32'h0, 0, 1, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: no done"); end
        checks++; if (out_xfers != 16) begin errors++; $display("FAIL bp_xfers: got %0d want 16", out_xfers); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL bp_order: got %0d errs want 0", order_err); end
        checks++; if (out_cycles != 46) begin errors++; $display("FAIL bp_cycles: got %0d want 46", out_cycles); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
        ready_mode = 0;
    endtask

    task automatic test_ignored();
        bit to;
        stray = 1;
        repeat (5) @(posedge clk);
        #1;
        stray = 0;
        checks++; if (bus.busy !== 1'b0 || bus.iter_cnt !== 7'd0) begin
            errors++; $display("FAIL stray_idle: busy=%b iter=%0d want 0 0", bus.busy, bus.iter_cnt); end
        mode = 2;
        clr_mon();
        pulse_start(32'h10);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.tol   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                to = 1'b0;
                bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checks++; if (to || bus.iter_cnt !== 7'd5) begin errors++; $display("FAIL ign_iter: got %0d want 5", bus.iter_cnt); end
        checks++; if (rows_total != 80 || order_err != 0) begin
            errors++; $display("FAIL ign_rows: rows=%0d errs=%0d want 80 0", rows_total, order_err); end
        checks++; if (bus.busy !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL ign_done_start: busy=%b done_cnt=%0d want 0 1", bus.busy, done_cnt); end
    endtask

    task automatic test_reset_mid();
        bit to;
        mode = 1;
        clr_mon();
        pulse_start(32'h0);
        to = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (sweeps_seen == 7) begin
                to = 1'b0;
                break;
            end
        end
        #1;
        checks++; if (to || bus.iter_cnt !== 7'd6 || bus.busy !== 1'b1 || bus.row_valid !== 1'b0) begin
            errors++; $display("FAIL rst_pre: iter=%0d busy=%b rv=%b want 6 1 0", bus.iter_cnt, bus.busy, bus.row_valid); end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.row_valid, bus.row_idx, bus.sweep_last, bus.out_valid, bus.out_idx, bus.busy,
             bus.iter_cnt, bus.converged, bus.done} !== '0) begin
            errors++; $display("FAIL rst_mid_outputs: outputs not all zero after reset");
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_solve(32'h0, 0, 0, to);
        checks++; if (to || bus.iter_cnt !== 7'd2 || bus.converged !== 1'b1 || sweeps_seen != 2) begin
            errors++; $display("FAIL rst_fresh: iter=%0d conv=%b sweeps=%0d want 2 1 2", bus.iter_cnt, bus.converged, sweeps_seen); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.tol = '0;
        bus.out_ready = 1'b1;
        bus.res_valid = 1'b0;
        bus.res_new = '0;
        bus.res_old = '0;
        clr_mon();
        test_reset();
        test_ignored();
        test_converge_exact();
        test_max_iter();
        test_tolerance();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gsim_sweep_sched.md
Name: gsim_sweep_sched

Overview:
- Iteration scheduler for the Gauss-Seidel solver datapath.
- Sequences row-update sweeps into the shared PE and monitors the result stream for convergence.
- Ends the solve early when the largest per-sweep update falls within a tolerance, or after MAX_ITER sweeps, then drives the output phase with a valid/ready handshake.
- Sits between the b-loader (start) and the PE/x-shift-register datapath; it holds no x storage.

Parameters:
- N, 16, rows per sweep (power of 2, >=4).
- MAX_ITER, 100, maximum sweep count (1..127).
- XW, 32, x word width (signed Q16.16).
- MIN_ITER, 2, sweeps always run before a convergence exit is allowed (1..MAX_ITER).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle pulse: b loaded; begin solve.
- tol  in  XW  unsigned convergence threshold; sampled on accepted start.
- row_valid  out  1  issue the row update at row_idx to the PE this cycle.
- row_idx  out  log2(N)  row being issued.
- sweep_last  out  1  row_valid and row_idx==N-1.
- res_valid  in  1  PE result valid.
- res_new  in  XW  updated x (signed).
- res_old  in  XW  previous x for the same row (signed).
- out_valid  out  1  output phase: x[out_idx] available.
- out_idx  out  log2(N)  output row index.
- out_ready  in  1  sink accepts the current output word.
- busy  out  1  state != IDLE.
- iter_cnt  out  7  completed sweeps.
- converged  out  1  last solve exited on tolerance; held until the next accepted start.
- done  out  1  one-cycle pulse after the final output word is accepted.

Behaviour:
- Reset values (asynchronous): state IDLE; all outputs 0; internal counters, tol_r and max_delta cleared. Reset mid-solve aborts immediately. The first post-reset start behaves as a fresh solve.
- States: IDLE, ISSUE, DRAIN, DECIDE, OUT. All outputs are registered.
- IDLE:
  - start=1 -> latch tol_r=tol; iter_cnt=0; converged=0; max_delta=0; row=0; res_cnt=0; go to ISSUE.
  - start is ignored in every other state.
- ISSUE:
  - row_valid=1 on every cycle, row_idx counts 0..N-1, one row per cycle.
  - After row N-1 -> DRAIN.
- Result accounting (ISSUE and DRAIN):
  - Each res_valid increments res_cnt.
  - d = |res_new - res_old|, computed at XW+1 bits signed, result unsigned XW+1.
  - max_delta = max(max_delta, d).
  - res_valid in IDLE, DECIDE or OUT is ignored and does not count.
- DRAIN:
  - When res_cnt reaches N (including a result arriving this cycle) -> DECIDE next cycle.
  - No timeout; the PE must return exactly N results per sweep.
- DECIDE (one cycle): iter_cnt += 1 (call the new value k), then:
  - if max_delta <= {1'b0,tol_r} and k >= MIN_ITER -> converged=1, go to OUT.
  - else if k == MAX_ITER -> converged=0, go to OUT.
  - else clear max_delta, row and res_cnt, go to ISSUE.
- Timing: row_valid restarts 2 cycles after the last result of the previous sweep (DECIDE plus register).
- OUT:
  - out_valid=1, out_idx starts at 0.
  - A transfer occurs when out_valid and out_ready are both high; out_idx then increments.
  - out_idx and out_valid hold while out_ready=0.
  - Transfer at out_idx=N-1 -> done=1 next cycle, out_valid=0, state IDLE.
  - start arriving in the same cycle as done is ignored.
- Persistence: iter_cnt and converged hold their values through OUT and IDLE until the next accepted start.
- tol=0 means only exact fixed-point equality converges. tol=all-ones converges at MIN_ITER.
- Delta overflow: cannot occur, because of the XW+1 width. For example, res_new=0x7FFFFFFF with res_old=0x80000000 gives d=0x0_FFFFFFFF.

Test Plan:
- Fixed PE latency 3, res_new==res_old on every row, tol=0, MIN_ITER=2 -> exactly 2 sweeps of 16 row_valid pulses, iter_cnt=2, converged=1, then 16 out words with out_idx 0..15, then done.
- Every result differs by 0x00010000, tol=0x0000FFFF -> runs 100 sweeps, iter_cnt=100 (0x64), converged=0, output phase follows.
- Delta 0x20 for sweeps 1-4, then 0x08; tol=0x10 -> exits after sweep 5 with converged=1. A single row at 0x11 inside sweep 5 forces sweep 6 instead.
- out_ready toggles 1,0,0,1,... during OUT -> out_idx advances only on ready cycles, no index skipped or repeated, done occurs exactly once.
- start pulsed during ISSUE, and stray res_valid asserted in IDLE -> both have no effect; iter_cnt is unchanged and the sweep row count stays 16.
- reset asserted mid-DRAIN of sweep 7 -> all outputs 0 immediately; a new start then runs a fresh solve with iter_cnt counting from 0.
